// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and widths for the ALU arbiter
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the requester that did not win last time goes first.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external 4-bit ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter logic RR_INIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [ALU_W-1:0] req_a0,
  input  logic [ALU_W-1:0] req_b0,
  input  logic [1:0]       req_sel0,
  input  logic [ALU_W-1:0] req_a1,
  input  logic [ALU_W-1:0] req_b1,
  input  logic [1:0]       req_sel1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [ALU_W-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [ALU_W-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             busy
);

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [ALU_W-1:0] op_a_q, op_a_d;
  logic [ALU_W-1:0] op_b_q, op_b_d;
  alu_op_t          op_sel_q, op_sel_d;
  logic [ALU_W-1:0] resp_result_q, resp_result_d;
  alu_flags_t       resp_flags_q, resp_flags_d;
  logic [1:0]       grant;

  rr_arbiter2 u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_sel_d      = op_sel_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    req_ready     = 2'b00;
    resp_valid    = 2'b00;

    case (state_q)
      IDLE: begin
        req_ready = grant;
        if ((req_valid & grant) != 2'b00) begin
          owner_d  = grant[1];
          op_a_d   = grant[1] ? req_a1 : req_a0;
          op_b_d   = grant[1] ? req_b1 : req_b0;
          op_sel_d = alu_op_t'(grant[1] ? req_sel1 : req_sel0);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // The ALU has had a full cycle to settle on the registered operands.
        resp_result_d = alu_result;
        resp_flags_d  = '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};
        state_d       = RESP;
      end
      RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= RR_INIT;
      owner_q       <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_sel_q      <= OP_ADD;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_sel_q      <= op_sel_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
    end
  end

  assign alu_a       = op_a_q;
  assign alu_b       = op_b_q;
  assign alu_sel     = op_sel_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a reference ALU
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0] req_sel0, req_sel1, alu_sel;
  logic [3:0] resp_result, resp_flags, alu_a, alu_b, alu_result;
  logic       alu_n, alu_z, alu_c, alu_v, busy;
  logic [4:0] alu_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
    .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .busy(busy)
  );

  // Reference 4-bit ALU: carry/overflow only on ADD/SUB, SUB carry = no-borrow.
  always_comb begin
    alu_sum = 5'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_sel)
      2'b00: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c   = alu_sum[4];
        alu_v   = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
      end
      2'b01: begin
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_c   = alu_sum[4];
        alu_v   = (alu_a[3] != alu_b[3]) && (alu_sum[3] != alu_a[3]);
      end
      2'b10:   alu_sum = {1'b0, alu_a & alu_b};
      default: alu_sum = {1'b0, alu_a | alu_b};
    endcase
    alu_result = alu_sum[3:0];
    alu_n      = alu_sum[3];
    alu_z      = (alu_sum[3:0] == 4'd0);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One uncontended op from requester id with immediate response acceptance.
  task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] sel, input logic [3:0] er, input logic [3:0] ef);
    logic [1:0] oh;
    oh = (id == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    if (id == 0) begin req_a0 = a; req_b0 = b; req_sel0 = sel; end
    else         begin req_a1 = a; req_b1 = b; req_sel1 = sel; end
    req_valid  = oh;
    resp_ready = 2'b00;
    #1 chk($sformatf("op%0d_req_ready", id), 8'(req_ready), 8'(oh));
    @(negedge clk);
    req_valid = 2'b00;
    chk($sformatf("op%0d_exec_ready", id), 8'(req_ready), 8'h00);
    chk($sformatf("op%0d_exec_busy", id), 8'(busy), 8'h01);
    chk($sformatf("op%0d_alu_drive", id), {alu_a, alu_b}, {a, b});
    chk($sformatf("op%0d_alu_sel", id), 8'(alu_sel), 8'(sel));
    chk($sformatf("op%0d_exec_rvalid", id), 8'(resp_valid), 8'h00);
    @(negedge clk);
    chk($sformatf("op%0d_resp_valid", id), 8'(resp_valid), 8'(oh));
    chk($sformatf("op%0d_resp_result", id), 8'(resp_result), 8'(er));
    chk($sformatf("op%0d_resp_flags", id), 8'(resp_flags), 8'(ef));
    resp_ready = oh;
    @(negedge clk);
    resp_ready = 2'b00;
    chk($sformatf("op%0d_done_rvalid", id), 8'(resp_valid), 8'h00);
    chk($sformatf("op%0d_done_busy", id), 8'(busy), 8'h00);
  endtask

  initial begin
    logic [1:0] exp_oh;
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    req_a0 = 4'd0; req_b0 = 4'd0; req_sel0 = 2'b00;
    req_a1 = 4'd0; req_b1 = 4'd0; req_sel1 = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_resp_valid", 8'(resp_valid), 8'h00);
    chk("rst_req_ready", 8'(req_ready), 8'h00);
    chk("rst_alu", {alu_a, alu_b}, 8'h00);
    chk("rst_alu_sel", 8'(alu_sel), 8'h00);
    chk("rst_resp", {resp_result, resp_flags}, 8'h00);

    do_op(0, 4'd7, 4'd9, 2'b00, 4'b0000, 4'b0110);
    do_op(1, 4'd3, 4'd5, 2'b01, 4'b1110, 4'b1000);
    do_op(0, 4'd7, 4'd1, 2'b00, 4'b1000, 4'b1001);

    // Fairness: reset, then both requesters held valid with responses always accepted.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req_a0 = 4'd2; req_b0 = 4'd3; req_sel0 = 2'b00;
    req_a1 = 4'd9; req_b1 = 4'd4; req_sel1 = 2'b11;
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk($sformatf("rr%0d_grant", k), 8'(req_ready), 8'(exp_oh));
      @(negedge clk);
      chk($sformatf("rr%0d_alu", k), {alu_a, alu_b}, (k % 2 == 0) ? 8'h23 : 8'h94);
      @(negedge clk);
      chk($sformatf("rr%0d_rvalid", k), 8'(resp_valid), 8'(exp_oh));
      chk($sformatf("rr%0d_result", k), {resp_result, resp_flags},
          (k % 2 == 0) ? 8'h50 : 8'hD8);
      @(negedge clk);
    end

    // Backpressure: requester 0 AND, requester 1 waiting behind it.
    req_valid = 2'b01; resp_ready = 2'b00;
    req_a0 = 4'b1100; req_b0 = 4'b1010; req_sel0 = 2'b10;
    req_a1 = 4'd2; req_b1 = 4'd2; req_sel1 = 2'b00;
    #1 chk("bp_grant0", 8'(req_ready), 8'h01);
    @(negedge clk);
    req_valid = 2'b11;
    #1 chk("bp_exec_ready", 8'(req_ready), 8'h00);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      resp_ready = (k == 4) ? 2'b10 : 2'b00;
      #1 chk($sformatf("bp%0d_hold", k), {2'b00, resp_valid, 2'b00, req_ready}, 8'h10);
      chk($sformatf("bp%0d_resp", k), {resp_result, resp_flags}, 8'h88);
      chk($sformatf("bp%0d_busy", k), 8'(busy), 8'h01);
      @(negedge clk);
    end
    resp_ready = 2'b01;
    #1 chk("bp_accept_rvalid", 8'(resp_valid), 8'h01);
    @(negedge clk);
    resp_ready = 2'b11;
    #1 chk("bp_next_grant1", 8'(req_ready), 8'h02);
    @(negedge clk);
    req_valid = 2'b00;
    chk("bp_op1_alu", {alu_a, alu_b}, 8'h22);
    @(negedge clk);
    chk("bp_op1_resp", {2'b00, resp_valid, resp_result}, 8'h24);
    @(negedge clk);
    resp_ready = 2'b00;

    // Reset during EXEC.
    req_a1 = 4'd5; req_b1 = 4'd6; req_sel1 = 2'b01; req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    chk("rexec_busy", 8'(busy), 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rexec_state", {busy, 5'b0, resp_valid}, 8'h00);
    chk("rexec_alu", {alu_a, alu_b}, 8'h00);
    chk("rexec_alu_sel", 8'(alu_sel), 8'h00);

    // Reset during RESP after requester 0 last won: pointer must revert.
    do_op(0, 4'd1, 4'd1, 2'b11, 4'b0001, 4'b0000);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("rresp_rvalid", 8'(resp_valid), 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rresp_state", {busy, 5'b0, resp_valid}, 8'h00);
    chk("rresp_alu", {alu_a, alu_b}, 8'h00);
    chk("rresp_alu_sel", 8'(alu_sel), 8'h00);
    chk("rresp_resp", {resp_result, resp_flags}, 8'h00);
    req_valid = 2'b11;
    #1 chk("rresp_first_grant", 8'(req_ready), 8'h01);
    @(negedge clk);
    req_valid = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 4-bit ALU instance between two requesters.
- Accepts operation requests over valid/ready, with round-robin arbitration between the two requesters.
- Drives the ALU from registered operands and captures the 4-bit result plus N/Z/C/V flags.
- Returns the result to the granted requester over a valid/ready response channel.
- Sits between requester logic (e.g. a sequencer or a switch/button front end) and the ALU; the ALU is instantiated outside this block.

Parameters:
- RR_INIT, 1'b1, value of the last-grant pointer after reset; 1 means requester 0 wins the first tie.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: requester i granted; handshake completes on the edge where valid&ready.
- req_a0, req_b0  in  4 each  operands, requester 0.
- req_sel0  in  2  opcode, requester 0: 00 ADD, 01 SUB, 10 AND, 11 OR.
- req_a1, req_b1, req_sel1  in  4/4/2  operands and opcode, requester 1.
- resp_valid  out  2  bit i: response for requester i available.
- resp_ready  in  2  bit i: requester i accepts its response.
- resp_result  out  4  captured ALU result.
- resp_flags  out  4  captured {N,Z,C,V}.
- alu_a, alu_b  out  4 each  to ALU a/b.
- alu_sel  out  2  to ALU Sel.
- alu_result  in  4  from ALU Result.
- alu_n, alu_z, alu_c, alu_v  in  1 each  from ALU flags.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, last_grant=RR_INIT, op_a/op_b/op_sel/owner=0, resp_result=0, resp_flags=0.
  - Outputs after reset: req_ready=0 (except the combinational IDLE grant), resp_valid=0, busy=0, alu_a/alu_b/alu_sel=0.
- ALU drive: alu_a, alu_b, alu_sel come only from op_a, op_b, op_sel registers, never combinationally from request inputs.
- FSM IDLE:
  - Grant is combinational. If exactly one req_valid bit is set, grant it.
  - If both are set, grant the requester != last_grant.
  - req_ready = one-hot grant; 00 if no valid.
  - On a handshake edge: latch the granted a/b/sel into op_*, owner=granted id, go to EXEC.
- FSM EXEC (one cycle):
  - req_ready=00; the ALU settles on op_*.
  - At the edge: resp_result<=alu_result, resp_flags<={alu_n,alu_z,alu_c,alu_v}, go to RESP.
- FSM RESP:
  - resp_valid[owner]=1, other bit 0; req_ready=00.
  - When resp_ready[owner]=1 at an edge: last_grant<=owner, go to IDLE.
  - Otherwise hold; resp_result and resp_flags stay stable.
  - resp_ready on the non-owner bit is ignored.
- Latency and throughput:
  - Request handshake edge at cycle T gives resp_valid high from T+2, with 0 backpressure.
  - Max throughput is one op per 3 cycles.
- Request rule: a requester must hold a/b/sel stable while valid&!ready. It may deassert valid before grant (no penalty). Arbitration re-evaluates every IDLE cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Reset mid-operation (EXEC or RESP):
  - Pending op and response are discarded; resp_valid drops at the reset edge.
  - last_grant returns to RR_INIT.
- ALU-produced flag semantics are passed through unmodified: C is produced only for ADD/SUB; N/Z are derived from the result.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_op_t (2-bit enum OP_ADD=00, OP_SUB=01, OP_AND=10, OP_OR=11);
  - typedef alu_flags_t (packed struct n,z,c,v);
  - typedef arb_state_t (IDLE, EXEC, RESP);
  - localparam ALU_W=4.
- One natural sub-module, rr_arbiter2: combinational 2-way round-robin grant from req_valid and last_grant.
- The FSM and registers stay in alu_arbiter.

Test Plan (bench instantiates the real ALU on the alu_* ports):
- After reset, only requester 0 valid: a=7, b=9, ADD.
  - Required: req_ready=01 in the first cycle; resp_valid=01 two cycles after the handshake; resp_result=0000; resp_flags=0110 (Z,C).
- Requester 1 only: a=3, b=5, SUB.
  - Required: resp_result=1110, resp_flags=1000 (N); resp_valid=10.
- Requester 0: a=7, b=1, ADD.
  - Required: resp_result=1000, resp_flags=1001 (N,V).
- Both requesters continuously valid after reset; resp_ready tied to 11.
  - Required: grant order 0,1,0,1; each response routed to the correct resp_valid bit; ALU ops match each owner's operands.
- Backpressure: requester 0 AND 1100&1010, resp_ready held 0 for 5 cycles.
  - Required: resp_valid=01 and resp_result=1000 held constant; busy=1; no grant to a valid requester 1 until resp_ready[0] is accepted; requester 1 is granted next.
- Reset asserted during EXEC, then during RESP.
  - Required: next cycle state IDLE, resp_valid=00, alu_a/alu_b/alu_sel=0; with both valid afterwards, requester 0 is granted first.
